spi_slave_regif: RTL and testbench
==================================

Name: spi_slave_regif

Overview:
- FPGA-side SPI responder, mode 0 (CPOL=0, CPHA=0), for the host register-access protocol.
- Deserialises AWIDTH+DWIDTH-bit frames, MSB first, address then data.
- Issues single-cycle write strobes or read requests to the register file.
- For reads, serialises the returned register value on MISO during the data phase of the same frame.
- Sits between the SPI pads and the fpga_regs register bank; runs entirely in the system clock domain with oversampled SPI inputs.

Parameters:
- AWIDTH, 8, frame address width. Address bit [AWIDTH-1] is the read flag: 1 = read, 0 = write.
- DWIDTH, 16, register data width.
- SYNC_STAGES, 2, synchroniser depth on spi_cs, spi_clk and spi_mosi (minimum 2).

Ports:
- clk  in  1  system clock; at least 8x the SCK frequency.
- rst  in  1  synchronous, active-high reset.
- spi_cs  in  1  chip select, active low, asynchronous to clk.
- spi_clk  in  1  SCK, asynchronous to clk.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO pad enable; 1 only while CS is low.
- reg_addr  out  AWIDTH-1  register address, read flag stripped; valid with reg_wr or reg_rd.
- reg_wdata  out  DWIDTH  write data; valid with reg_wr.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read request.
- reg_rdata  in  DWIDTH  read data; sampled when reg_rd_ack=1.
- reg_rd_ack  in  1  read data valid; must arrive within 4 clk of reg_rd.
- frame_err  out  1  one-cycle pulse on a malformed or late frame.

Behaviour:
- Reset (rst=1 at a clk edge): spi_miso=0, spi_miso_oe=0, reg_wr=0, reg_rd=0, frame_err=0, reg_addr=0, reg_wdata=0, bit counter=0, FSM=IDLE. Synchroniser flops reset to cs=1, sck=0, mosi=0.
- Edge detection: on the synchronised SCK, rise = prev 0 / now 1; fall = prev 1 / now 0. Edges are ignored while synchronised CS=1.
- FSM states:
  - IDLE: waits for the synchronised CS falling edge; clears the counter and shift register, sets spi_miso_oe=1, spi_miso=0, then goes to ADDR.
  - ADDR: each SCK rise shifts MOSI into the shift register LSB and increments the counter. On the rise of bit AWIDTH:
    - read flag=1: present reg_addr and pulse reg_rd the next clk, go to RD_WAIT.
    - read flag=0: go to DATA_WR.
  - RD_WAIT: on reg_rd_ack, latch reg_rdata into the tx register and go to DATA_RD. If an SCK fall occurs before ack: tx register=0, pulse frame_err, go to DATA_RD. A late ack is ignored.
  - DATA_RD: the first SCK fall after entering loads spi_miso=tx[DWIDTH-1]; each later fall shifts the next bit out. MOSI is still shifted in and counted but not used.
  - DATA_WR: shifts MOSI in on each rise. On the rise of bit AWIDTH+DWIDTH, go to DONE_WR with reg_wdata valid.
  - DONE_WR: waits for CS rise, then pulses reg_wr once with reg_addr/reg_wdata and returns to IDLE. SCK edges after the full frame are ignored.
- spi_miso is 0 throughout ADDR and RD_WAIT.
- CS rise in any state other than DONE_WR or DATA_RD-complete (counter < AWIDTH+DWIDTH): abort, no reg_wr, pulse frame_err, go to IDLE. A reg_rd already issued is not retracted.
- Any CS rise: spi_miso_oe=0 and spi_miso=0 on the following clk.
- CS fall while not in IDLE (CS glitch narrower than a clk is invisible): treated as abort + restart. Pulse frame_err and re-enter ADDR.
- Read timing budget: SCK half-period minus SYNC_STAGES+1 clk must exceed 4 clk.
- Latency:
  - reg_rd: SYNC_STAGES+2 clk after the SCK rise of the last address bit.
  - reg_wr: SYNC_STAGES+2 clk after the CS rise.
- rst asserted mid-frame: immediate return to reset values. The frame is lost silently; no frame_err.

Decomposition:
- Package spi_regif_pkg:
  - FSM state enum: IDLE, ADDR, RD_WAIT, DATA_RD, DATA_WR, DONE_WR.
  - FRAME_W = AWIDTH+DWIDTH.
  - RD_FLAG_BIT = AWIDTH-1.
  - RD_ACK_MAX = 4.
- One sub-module: spi_in_sync. It holds the SYNC_STAGES flop chain for cs, sck and mosi, plus the registered sck_rise, sck_fall, cs_fall and cs_rise pulses.

Test Plan (the bench uses a clk of 10 ns and an SCK half-period of 100 ns):
- Write addr 0x05, data 0x00AA → exactly one reg_wr after CS rise; reg_addr=0x05, reg_wdata=0x00AA; frame_err=0.
- Write 0xBB/0xCC/0xDD to addrs 0x06..0x08, then read addr 0x85 with the regfile model acking 0x00AA after 2 clk. Required response:
  - reg_rd pulses with reg_addr=0x05.
  - The master's captured low 16 bits equal 0x00AA.
  - The address-phase bits are 0.
- Read with the ack withheld → the 16 data bits read 0x0000, with one frame_err pulse.
- CS raised after 12 of 24 bits on a write → no reg_wr, one frame_err, FSM back in IDLE; a following valid write succeeds.
- rst pulsed for 1 clk after bit 18 of a write, then CS rises → no reg_wr, no frame_err, all outputs at reset values.
- Back-to-back frames with 300 ns CS-high gaps (4 writes then 4 reads) → each register reads back its written value in order; spi_miso_oe=0 during every gap.

Source files
------------

// File: rtl/spi_regif_pkg.sv
// Shared types and frame constants for the SPI register-access responder.
package spi_regif_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD_WAIT,
        DATA_RD,
        DATA_WR,
        DONE_WR
    } state_t;

    localparam int AWIDTH_DEF  = 8;
    localparam int DWIDTH_DEF  = 16;
    localparam int FRAME_W     = AWIDTH_DEF + DWIDTH_DEF;
    localparam int RD_FLAG_BIT = AWIDTH_DEF - 1;
    localparam int RD_ACK_MAX  = 4;

    function automatic int frame_width(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/spi_slave_regif_if.sv
// Register-bank side of the SPI responder: address/data strobes and read handshake.
interface spi_slave_regif_if #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 16
) ();
    logic [AWIDTH-2:0] reg_addr;
    logic [DWIDTH-1:0] reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [DWIDTH-1:0] reg_rdata;
    logic              reg_rd_ack;
    logic              frame_err;

    modport master (
        output reg_addr, reg_wdata, reg_wr, reg_rd, frame_err,
        input  reg_rdata, reg_rd_ack
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_wr, reg_rd, frame_err,
        output reg_rdata, reg_rd_ack
    );
endinterface

// File: rtl/spi_in_sync.sv
// Synchronises the asynchronous SPI pins into clk and produces registered edge pulses.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_cs,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise
);
    localparam int TOP = SYNC_STAGES - 1;

    logic [TOP:0] cs_p0;
    logic [TOP:0] sck_p0;
    logic [TOP:0] mosi_p0;
    logic [TOP:0] vld_p0;
    logic         cs_p1;
    logic         sck_p1;
    logic         armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_p0    <= '1;
            sck_p0   <= '0;
            mosi_p0  <= '0;
            vld_p0   <= '0;
            cs_p1    <= 1'b1;
            sck_p1   <= 1'b0;
            armed    <= 1'b0;
            mosi     <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            cs_fall  <= 1'b0;
            cs_rise  <= 1'b0;
        end else begin
            // stage p0: metastability chain
            cs_p0   <= {cs_p0[TOP-1:0], spi_cs};
            sck_p0  <= {sck_p0[TOP-1:0], spi_clk};
            mosi_p0 <= {mosi_p0[TOP-1:0], spi_mosi};
            vld_p0  <= {vld_p0[TOP-1:0], 1'b1};
            // stage p1: edge detect; a CS already low when reset releases must not start a frame
            cs_p1    <= cs_p0[TOP];
            sck_p1   <= sck_p0[TOP];
            mosi     <= mosi_p0[TOP];
            if (vld_p0[TOP] && cs_p0[TOP])
                armed <= 1'b1;
            sck_rise <= !cs_p0[TOP] && !sck_p1 && sck_p0[TOP];
            sck_fall <= !cs_p0[TOP] && sck_p1 && !sck_p0[TOP];
            cs_fall  <= armed && cs_p1 && !cs_p0[TOP];
            cs_rise  <= !cs_p1 && cs_p0[TOP];
        end
    end
endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 responder turning address+data frames into register-bank writes and reads.
module spi_slave_regif
    import spi_regif_pkg::*;
#(
    parameter int AWIDTH      = 8,
    parameter int DWIDTH      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    spi_slave_regif_if.master regs
);
    localparam int FRAME_BITS = frame_width(AWIDTH, DWIDTH);
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int RD_FLAG    = AWIDTH - 1;
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(AWIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_DONE = CNT_W'(FRAME_BITS);

    logic              mosi;
    logic              sck_rise;
    logic              sck_fall;
    logic              cs_fall;
    logic              cs_rise;
    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DWIDTH-2:0] shift_q;
    logic [DWIDTH-1:0] shift_in;
    logic [DWIDTH-1:0] tx_q;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .spi_cs   (spi_cs),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .mosi     (mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise)
    );

    // Only the last DWIDTH bits are ever needed; address bits are taken before data overwrites them.
    assign shift_in = {shift_q, mosi};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shift_q        <= '0;
            tx_q           <= '0;
            spi_miso       <= 1'b0;
            spi_miso_oe    <= 1'b0;
            regs.reg_addr  <= '0;
            regs.reg_wdata <= '0;
            regs.reg_wr    <= 1'b0;
            regs.reg_rd    <= 1'b0;
            regs.frame_err <= 1'b0;
        end else begin
            regs.reg_wr    <= 1'b0;
            regs.reg_rd    <= 1'b0;
            regs.frame_err <= 1'b0;
            if (cs_rise) begin
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                state       <= IDLE;
                if (state == DONE_WR)
                    regs.reg_wr <= 1'b1;
                else if (state != IDLE && !(state == DATA_RD && bit_cnt == FRAME_DONE))
                    regs.frame_err <= 1'b1;
            end else if (cs_fall) begin
                regs.frame_err <= (state != IDLE);
                bit_cnt        <= '0;
                shift_q        <= '0;
                spi_miso       <= 1'b0;
                spi_miso_oe    <= 1'b1;
                state          <= ADDR;
            end else begin
                case (state)
                    ADDR: begin
                        if (sck_rise) begin
                            shift_q <= shift_in[DWIDTH-2:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == ADDR_LAST) begin
                                regs.reg_addr <= shift_in[AWIDTH-2:0];
                                if (shift_in[RD_FLAG]) begin
                                    regs.reg_rd <= 1'b1;
                                    state       <= RD_WAIT;
                                end else begin
                                    state <= DATA_WR;
                                end
                            end
                        end
                    end
                    RD_WAIT: begin
                        if (regs.reg_rd_ack) begin
                            tx_q  <= regs.reg_rdata;
                            state <= DATA_RD;
                        end else if (sck_fall) begin
                            tx_q           <= '0;
                            regs.frame_err <= 1'b1;
                            state          <= DATA_RD;
                        end
                    end
                    DATA_RD: begin
                        if (sck_rise && bit_cnt != FRAME_DONE) begin
                            shift_q <= shift_in[DWIDTH-2:0];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (sck_fall) begin
                            spi_miso <= tx_q[DWIDTH-1];
                            tx_q     <= tx_q << 1;
                        end
                    end
                    DATA_WR: begin
                        if (sck_rise) begin
                            shift_q <= shift_in[DWIDTH-2:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == DATA_LAST) begin
                                regs.reg_wdata <= shift_in;
                                state          <= DONE_WR;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench: an SPI master model plus a small register-file model around spi_slave_regif.
module tb_spi_slave_regif;
    import spi_regif_pkg::*;

    localparam int HALF      = 100;
    localparam int ACK_DELAY = 2;
    localparam int LAT       = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_cs = 1'b1;
    logic spi_clk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic spi_miso_oe;

    spi_slave_regif_if #(.AWIDTH(8), .DWIDTH(16)) bus ();

    spi_slave_regif #(.AWIDTH(8), .DWIDTH(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_cs      (spi_cs),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .regs        (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int rd_cnt  = 0;
    int err_cnt = 0;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic [6:0]  rd_addr;
    logic [15:0] mem [0:127];
    time t_wr, t_rd, t_cs_rise, t_addr_rise;
    bit  ack_en = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor and write side of the register file
    initial begin
        forever begin
            @(negedge clk);
            if (bus.reg_wr === 1'b1) begin
                wr_cnt++;
                wr_addr = bus.reg_addr;
                wr_data = bus.reg_wdata;
                mem[bus.reg_addr] = bus.reg_wdata;
                t_wr = $time;
            end
            if (bus.reg_rd === 1'b1) begin
                rd_cnt++;
                rd_addr = bus.reg_addr;
                t_rd = $time;
            end
            if (bus.frame_err === 1'b1)
                err_cnt++;
        end
    end

    // Read side of the register file: acks ACK_DELAY clk after the request
    initial begin
        bus.reg_rd_ack = 1'b0;
        bus.reg_rdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.reg_rd === 1'b1 && ack_en) begin
                repeat (ACK_DELAY - 1) @(negedge clk);
                bus.reg_rdata  = mem[bus.reg_addr];
                bus.reg_rd_ack = 1'b1;
                @(negedge clk);
                bus.reg_rd_ack = 1'b0;
                bus.reg_rdata  = '0;
            end
        end
    end

    task automatic spi_xfer(input logic [23:0] tx, input int nbits, input bit end_cs,
                            output logic [23:0] rx);
        rx = '0;
        @(negedge clk);
        spi_cs   = 1'b0;
        spi_mosi = tx[23];
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            spi_clk = 1'b1;
            rx = {rx[22:0], spi_miso};
            if (i == 7)
                t_addr_rise = $time;
            #HALF;
            spi_clk = 1'b0;
            if (i < 23)
                spi_mosi = tx[22 - i];
            #HALF;
        end
        if (end_cs) begin
            spi_cs = 1'b1;
            t_cs_rise = $time;
            #250;
            check("oe_gap", {31'd0, spi_miso_oe}, 32'd0);
            #50;
        end
    endtask

    logic [23:0] rx;
    int wr0, rd0, err0;
    logic [6:0]  vec_addr [4] = '{7'h10, 7'h11, 7'h12, 7'h13};
    logic [15:0] vec_data [4] = '{16'h1234, 16'hA5A5, 16'h8001, 16'hFFFF};

    initial begin
        repeat (4) @(negedge clk);
        check("rst_miso", {31'd0, spi_miso}, 32'd0);
        check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("rst_wr", {31'd0, bus.reg_wr}, 32'd0);
        check("rst_rd", {31'd0, bus.reg_rd}, 32'd0);
        check("rst_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_addr", {25'd0, bus.reg_addr}, 32'd0);
        check("rst_wdata", {16'd0, bus.reg_wdata}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single write
        wr0 = wr_cnt; err0 = err_cnt;
        spi_xfer({8'h05, 16'h00AA}, 24, 1'b1, rx);
        check("w1_count", wr_cnt - wr0, 1);
        check("w1_addr", {25'd0, wr_addr}, 32'h05);
        check("w1_data", {16'd0, wr_data}, 32'h00AA);
        check("w1_err", err_cnt - err0, 0);
        check("w1_latency", 32'((t_wr - t_cs_rise) / 10), LAT);

        // Writes to neighbouring registers, then read back 0x05
        spi_xfer({8'h06, 16'h00BB}, 24, 1'b1, rx);
        spi_xfer({8'h07, 16'h00CC}, 24, 1'b1, rx);
        spi_xfer({8'h08, 16'h00DD}, 24, 1'b1, rx);
        check("w3_count", wr_cnt - wr0, 4);
        rd0 = rd_cnt; err0 = err_cnt;
        spi_xfer({8'h85, 16'h0000}, 24, 1'b1, rx);
        check("r1_count", rd_cnt - rd0, 1);
        check("r1_addr", {25'd0, rd_addr}, 32'h05);
        check("r1_data", {16'd0, rx[15:0]}, 32'h00AA);
        check("r1_addr_phase", {24'd0, rx[23:16]}, 32'd0);
        check("r1_err", err_cnt - err0, 0);
        check("r1_latency", 32'((t_rd - t_addr_rise) / 10), LAT);

        // Read with the ack withheld
        ack_en = 1'b0;
        rd0 = rd_cnt; err0 = err_cnt;
        spi_xfer({8'h86, 16'h0000}, 24, 1'b1, rx);
        check("r2_count", rd_cnt - rd0, 1);
        check("r2_data", {8'd0, rx}, 32'd0);
        check("r2_err", err_cnt - err0, 1);
        ack_en = 1'b1;

        // Write aborted after 12 bits, then a good write
        wr0 = wr_cnt; err0 = err_cnt;
        spi_xfer({8'h09, 16'h5A5A}, 12, 1'b1, rx);
        check("abort_wr", wr_cnt - wr0, 0);
        check("abort_err", err_cnt - err0, 1);
        check("abort_oe", {31'd0, spi_miso_oe}, 32'd0);
        spi_xfer({8'h09, 16'h1357}, 24, 1'b1, rx);
        check("post_abort_wr", wr_cnt - wr0, 1);
        check("post_abort_addr", {25'd0, wr_addr}, 32'h09);
        check("post_abort_data", {16'd0, wr_data}, 32'h1357);

        // Reset in the middle of a write frame
        wr0 = wr_cnt; err0 = err_cnt;
        spi_xfer({8'h0A, 16'hC3C3}, 18, 1'b0, rx);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #HALF;
        spi_cs = 1'b1;
        #300;
        check("mrst_wr", wr_cnt - wr0, 0);
        check("mrst_err", err_cnt - err0, 0);
        check("mrst_miso", {31'd0, spi_miso}, 32'd0);
        check("mrst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("mrst_addr", {25'd0, bus.reg_addr}, 32'd0);
        check("mrst_wdata", {16'd0, bus.reg_wdata}, 32'd0);

        // Back-to-back writes then reads with 300 ns gaps
        wr0 = wr_cnt; err0 = err_cnt;
        for (int i = 0; i < 4; i++)
            spi_xfer({1'b0, vec_addr[i], vec_data[i]}, 24, 1'b1, rx);
        check("b2b_wr", wr_cnt - wr0, 4);
        for (int i = 0; i < 4; i++) begin
            spi_xfer({1'b1, vec_addr[i], 16'h0000}, 24, 1'b1, rx);
            check("b2b_rd", {16'd0, rx[15:0]}, {16'd0, vec_data[i]});
        end
        check("b2b_err", err_cnt - err0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
